// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams configuration words LSB-first into a CCDFF chain, then pulses cfg_en.
// Optional chain tail continuity/stuck-at check is built when CCFF_TAIL_CHECK_EN is defined.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              ccff_reset_b,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BW = $clog2(WORD_W + 1);
    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int TW = $clog2(NWORDS + 1);
    localparam logic [BW-1:0] LAST_M1 = BW'(CHAIN_LEN - (NWORDS - 1) * WORD_W - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(WORD_W - 1);
    localparam logic [SW-1:0] LEN = SW'(CHAIN_LEN);
    localparam logic [TW-1:0] NW = TW'(NWORDS);
    localparam logic [TW-1:0] LAST_WORD = TW'(NWORDS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, APPLY, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BW-1:0]     bits_left_q, bits_left_d;
    logic [TW-1:0]     words_q, words_d;
    logic [SW-1:0]     shift_cnt_q, shift_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              reset_b_q, reset_b_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              cfg_en_q, cfg_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hs;

    assign hs = in_valid && in_ready_q;

`ifdef CCFF_TAIL_CHECK_EN
    logic first_q, first_d;
    always_comb first_d = (shift_en_d && shift_cnt_q == '0) ? head_d : first_q;
    always_ff @(posedge clk) first_q <= reset ? 1'b0 : first_d;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bits_left_d = bits_left_q;
        words_d     = words_q;
        shift_cnt_d = shift_cnt_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        cfg_en_d    = 1'b0;
        reset_b_d   = 1'b1;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d     = CLEAR;
                reset_b_d   = 1'b0;
                done_d      = 1'b0;
                err_d       = 1'b0;
                bits_left_d = '0;
                words_d     = '0;
                shift_cnt_d = '0;
            end
            CLEAR: state_d = SHIFT;
            SHIFT: if (shift_cnt_q == LEN) begin
                state_d  = APPLY;
                cfg_en_d = 1'b1;
            end else if (hs) begin
                // bit 0 goes straight to the head; the register keeps the rest
                head_d      = in_data[0];
                word_d      = in_data >> 1;
                bits_left_d = (words_q == LAST_WORD) ? LAST_M1 : FULL_M1;
                words_d     = words_q + 1'b1;
                shift_en_d  = 1'b1;
                shift_cnt_d = shift_cnt_q + 1'b1;
            end else if (bits_left_q != '0) begin
                head_d      = word_q[0];
                word_d      = word_q >> 1;
                bits_left_d = bits_left_q - 1'b1;
                shift_en_d  = 1'b1;
                shift_cnt_d = shift_cnt_q + 1'b1;
            end
            APPLY: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef CCFF_TAIL_CHECK_EN
        if ((shift_en_q && ccff_tail) || (state_q == APPLY && ccff_tail != first_q))
            err_d = 1'b1;
`endif
        in_ready_d = state_d == SHIFT && bits_left_d == '0 && words_d < NW;
        busy_d     = state_d == CLEAR || state_d == SHIFT || state_d == APPLY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            bits_left_q <= '0;
            words_q     <= '0;
            shift_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            reset_b_q   <= 1'b1;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            cfg_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bits_left_q <= bits_left_d;
            words_q     <= words_d;
            shift_cnt_q <= shift_cnt_d;
            in_ready_q  <= in_ready_d;
            reset_b_q   <= reset_b_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            cfg_en_q    <= cfg_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign ccff_reset_b  = reset_b_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign cfg_en        = cfg_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table-driven and randomized loads of a 10-cell chain with 4-bit words.
module tb_ccff_chain_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready, ccff_reset_b, ccff_head, ccff_shift_en, ccff_tail;
    logic       cfg_en, busy, done, cfg_err;

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ccff_reset_b(ccff_reset_b), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .cfg_en(cfg_en),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // chain model: 10 cells, head enters cell 0, tail is cell 9
    logic [9:0] chain = '0;
    int         pshift = 0;
    int         stuck_at = 0;
    always @(posedge clk) begin
        if (!ccff_reset_b) begin
            chain  <= '0;
            pshift <= 0;
        end else if (ccff_shift_en) begin
            chain  <= {chain[8:0], ccff_head};
            pshift <= pshift + 1;
        end
    end
    assign ccff_tail = chain[9] | (stuck_at != 0 && ccff_shift_en && pshift == stuck_at - 1);

    int         cyc = 0, nshift = 0, n_cfg = 0, n_rstb = 0;
    int         start_cyc = 0, first_sh = -1, last_sh = 0, cfg_cyc = 0, done_cyc = -1, rstb_cyc = 0;
    logic [15:0] got = '0;
    logic       err_clear = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy && !reset) begin
            nshift    <= 0;
            n_cfg     <= 0;
            n_rstb    <= 0;
            start_cyc <= cyc;
            first_sh  <= -1;
            done_cyc  <= -1;
            got       <= '0;
        end else begin
            if (ccff_shift_en) begin
                if (nshift < 16) got[nshift] <= ccff_head;
                nshift <= nshift + 1;
                if (first_sh < 0) first_sh <= cyc;
                last_sh <= cyc;
            end
            if (cfg_en) begin
                n_cfg   <= n_cfg + 1;
                cfg_cyc <= cyc;
            end
            if (!ccff_reset_b) begin
                n_rstb    <= n_rstb + 1;
                rstb_cyc  <= cyc;
                err_clear <= cfg_err;
            end
            if (done && done_cyc < 0) done_cyc <= cyc;
        end
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    typedef struct {
        logic [3:0] w0, w1, w2;
        int         gap;
        int         stuck;
        bit         bstart;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[10];

    // the chain receives the words' bits in arrival order, truncated to 10
    function automatic logic [9:0] model(input logic [3:0] w0, w1, w2);
        logic [9:0] r = '0;
        logic [3:0] w[3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int i = 0; i < 10; i++) r[i] = w[i / 4][i % 4];
        return r;
    endfunction

    task automatic send(input logic [3:0] w, input string name);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v, input string tag);
        bit   ok = 0;
        int   experr;
        logic [3:0] w[3];
`ifdef CCFF_TAIL_CHECK_EN
        experr = (v.stuck != 0) ? 1 : 0;
`else
        experr = 0;
`endif
        w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
        stuck_at = v.stuck;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(w[i], {tag, "_hs"});
            if (i == 0 && (v.bstart || v.gap > 0)) begin
                in_valid = 1'b0;
                if (v.bstart) begin
                    start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
                if (v.gap > 0) begin
                    for (int k = 0; k < 50; k++) begin
                        @(negedge clk);
                        if (in_ready) break;
                    end
                    repeat (v.gap) @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) timeout({tag, "_done"});
        @(posedge clk); #1;
        chk({tag, "_bits"}, int'(got[9:0]), int'(v.exp));
        chk({tag, "_nshift"}, nshift, 10);
        chk({tag, "_cfg_pulses"}, n_cfg, 1);
        chk({tag, "_clear_cycles"}, n_rstb, 1);
        chk({tag, "_clear_at"}, rstb_cyc - start_cyc, 1);
        chk({tag, "_shift_span"}, last_sh - first_sh + 1, 10 + v.gap);
        chk({tag, "_cfg_after_shift"}, cfg_cyc - last_sh, 1);
        chk({tag, "_done_after_cfg"}, done_cyc - cfg_cyc, 1);
        if (v.gap == 0) chk({tag, "_load_time"}, done_cyc - start_cyc, 14);
        chk({tag, "_err_at_clear"}, int'(err_clear), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), experr);
        repeat (2) @(negedge clk);
        chk({tag, "_done_hold"}, int'(done), 1);
        chk({tag, "_err_hold"}, int'(cfg_err), experr);
        stuck_at = 0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, int'({in_ready, ccff_reset_b, ccff_head, ccff_shift_en, cfg_en, busy, done, cfg_err}),
            int'(8'b0100_0000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok = 0;
        tbl[0] = '{4'hA, 4'h5, 4'h3, 0, 0, 1'b0, 10'h35A};
        tbl[1] = '{4'hA, 4'h5, 4'h3, 3, 0, 1'b0, 10'h35A};
        tbl[2] = '{4'hF, 4'h0, 4'hC, 1, 4, 1'b0, 10'h00F};
        tbl[3] = '{4'h0, 4'hF, 4'hE, 0, 0, 1'b1, 10'h2F0};
        for (int i = 4; i < 10; i++) begin
            tbl[i].w0     = 4'($urandom);
            tbl[i].w1     = 4'($urandom);
            tbl[i].w2     = 4'($urandom);
            tbl[i].gap    = int'($urandom_range(0, 3));
            tbl[i].stuck  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            tbl[i].bstart = 1'($urandom);
            tbl[i].exp    = model(tbl[i].w0, tbl[i].w1, tbl[i].w2);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset_values");
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) run_row(tbl[i], $sformatf("row%0d", i));

        // abort mid-load with reset
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hA;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (nshift >= 5) begin ok = 1; break; end
        end
        if (!ok) timeout("abort_wait");
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort_values");
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_cfg_en", n_cfg, 0);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_done", int'(done), 0);
        run_row(tbl[0], "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
